// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue sequencer: ALUControl codes, MIPS opcode/funct
// values, FSM states and the decoded-instruction record.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000, ALU_ADDU = 4'b0001, ALU_SUB  = 4'b0010,
                         ALU_SUBU = 4'b0011, ALU_AND  = 4'b0100, ALU_OR   = 4'b0101,
                         ALU_XOR  = 4'b0110, ALU_NOR  = 4'b0111, ALU_SLT  = 4'b1010,
                         ALU_SLTU = 4'b1011, ALU_SRA  = 4'b1100, ALU_SRL  = 4'b1101,
                         ALU_LUI  = 4'b1110, ALU_SLL  = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BEQ  = 6'h04, OP_BNE  = 6'h05,
                         OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                         OP_XORI  = 6'h0E, OP_LUI  = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                         FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22,
                         FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
                         FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A,
                         FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_RESP} state_e;
  typedef enum logic [1:0] {OPA_ZERO, OPA_RS, OPA_RT} opa_sel_e;
  typedef enum logic [1:0] {OPB_ZERO, OPB_RT, OPB_RS5, OPB_IMM} opb_sel_e;
  typedef enum logic [1:0] {CLS_ALU, CLS_BRANCH, CLS_ILLEGAL} cls_e;

  typedef struct packed {
    logic [3:0]  ctrl;
    opa_sel_e    opa;
    opb_sel_e    opb;
    logic [31:0] imm;      // extended immediate or shamt
    logic [4:0]  dest;
    cls_e        cls;
    logic        ovf_chk;  // add/addi/sub only
    logic        br_ne;
  } dec_t;

  localparam dec_t DEC_ILLEGAL = '{ctrl: ALU_ADDU, opa: OPA_ZERO, opb: OPB_ZERO, imm: 32'h0,
                                   dest: 5'd0, cls: CLS_ILLEGAL, ovf_chk: 1'b0, br_ne: 1'b0};

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of a MIPS instruction word into ALU control, operand selects,
// extended immediate, destination register and result class.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0]  op, fn;
  logic [31:0] sext, zext, shamt;
  logic        unused_rs;

  assign op        = instr[31:26];
  assign fn        = instr[5:0];
  assign sext      = {{16{instr[15]}}, instr[15:0]};
  assign zext      = {16'h0, instr[15:0]};
  assign shamt     = {27'h0, instr[10:6]};
  assign unused_rs = ^instr[25:21];  // rs is consumed as a value, not as a field

  always_comb begin
    dec = DEC_ILLEGAL;
    if (op == OP_RTYPE) begin
      dec.cls  = CLS_ALU;
      dec.opa  = OPA_RS;
      dec.opb  = OPB_RT;
      dec.dest = instr[15:11];
      case (fn)
        FN_ADD:  begin dec.ctrl = ALU_ADD; dec.ovf_chk = 1'b1; end
        FN_ADDU: dec.ctrl = ALU_ADDU;
        FN_SUB:  begin dec.ctrl = ALU_SUB; dec.ovf_chk = 1'b1; end
        FN_SUBU: dec.ctrl = ALU_SUBU;
        FN_AND:  dec.ctrl = ALU_AND;
        FN_OR:   dec.ctrl = ALU_OR;
        FN_XOR:  dec.ctrl = ALU_XOR;
        FN_NOR:  dec.ctrl = ALU_NOR;
        FN_SLT:  dec.ctrl = ALU_SLT;
        FN_SLTU: dec.ctrl = ALU_SLTU;
        FN_SLL:  begin dec.ctrl = ALU_SLL; dec.opa = OPA_RT; dec.opb = OPB_IMM; dec.imm = shamt; end
        FN_SRL:  begin dec.ctrl = ALU_SRL; dec.opa = OPA_RT; dec.opb = OPB_IMM; dec.imm = shamt; end
        FN_SRA:  begin dec.ctrl = ALU_SRA; dec.opa = OPA_RT; dec.opb = OPB_IMM; dec.imm = shamt; end
        FN_SLLV: begin dec.ctrl = ALU_SLL; dec.opa = OPA_RT; dec.opb = OPB_RS5; end
        FN_SRLV: begin dec.ctrl = ALU_SRL; dec.opa = OPA_RT; dec.opb = OPB_RS5; end
        FN_SRAV: begin dec.ctrl = ALU_SRA; dec.opa = OPA_RT; dec.opb = OPB_RS5; end
        default: dec = DEC_ILLEGAL;
      endcase
    end else begin
      dec.cls  = CLS_ALU;
      dec.opa  = OPA_RS;
      dec.opb  = OPB_IMM;
      dec.dest = instr[20:16];
      dec.imm  = sext;
      case (op)
        OP_ADDI:  begin dec.ctrl = ALU_ADD; dec.ovf_chk = 1'b1; end
        OP_ADDIU: dec.ctrl = ALU_ADDU;
        OP_SLTI:  dec.ctrl = ALU_SLT;
        OP_SLTIU: dec.ctrl = ALU_SLTU;
        OP_ANDI:  begin dec.ctrl = ALU_AND; dec.imm = zext; end
        OP_ORI:   begin dec.ctrl = ALU_OR;  dec.imm = zext; end
        OP_XORI:  begin dec.ctrl = ALU_XOR; dec.imm = zext; end
        OP_LUI:   begin dec.ctrl = ALU_LUI; dec.imm = zext; end
        OP_BEQ, OP_BNE: begin
          dec.ctrl  = ALU_SUBU;
          dec.opb   = OPB_RT;
          dec.dest  = 5'd0;
          dec.cls   = CLS_BRANCH;
          dec.br_ne = (op == OP_BNE);
        end
        default: dec = DEC_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Multicycle issue sequencer: decodes one instruction, holds ALU inputs stable for
// EXEC_CYCLES, captures the ALU outcome and presents a writeback/branch record over
// valid/ready. Define ALU_TRAP_EN to turn signed overflow on add/addi/sub into a trap.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  output logic [31:0] alu_opr1,
  output logic [31:0] alu_opr2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_we,
  output logic [4:0]  res_addr,
  output logic [31:0] res_data,
  output logic        res_br_taken,
  output logic        res_exc_ovf,
  output logic        res_illegal
);

  localparam int CW = $clog2(EXEC_CYCLES + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   instr_q, rs_q, rt_q;
  logic [31:0]   opr1_d, opr2_d;
  dec_t          dec;
  cls_e          cls_q;
  logic [4:0]    dest_q;
  logic          ovf_chk_q, br_ne_q;
  logic [31:0]   cap_res_q;
  logic          cap_ovf_q, cap_zero_q;
  logic          trap;

  alu_issue_decode u_dec (.instr(instr_q), .dec(dec));

  assign in_ready = (state_q == S_IDLE) && !reset;

`ifdef ALU_TRAP_EN
  assign trap = ovf_chk_q & cap_ovf_q;
`else
  logic unused_ovf;
  assign trap       = 1'b0;
  assign unused_ovf = ovf_chk_q ^ cap_ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   if (cnt_q == CW'(EXEC_CYCLES)) state_d = S_RESP;
      S_RESP:   if (res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    opr1_d = 32'h0;
    opr2_d = 32'h0;
    case (dec.opa)
      OPA_RS:  opr1_d = rs_q;
      OPA_RT:  opr1_d = rt_q;
      default: ;
    endcase
    case (dec.opb)
      OPB_RT:  opr2_d = rt_q;
      OPB_RS5: opr2_d = {27'h0, rs_q[4:0]};
      OPB_IMM: opr2_d = dec.imm;
      default: ;
    endcase
  end

  // EXEC runs one cycle past the capture point so the record is formed from stable flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      instr_q      <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      alu_opr1     <= '0;
      alu_opr2     <= '0;
      alu_ctrl     <= ALU_ADDU;
      cls_q        <= CLS_ILLEGAL;
      dest_q       <= '0;
      ovf_chk_q    <= 1'b0;
      br_ne_q      <= 1'b0;
      cap_res_q    <= '0;
      cap_ovf_q    <= 1'b0;
      cap_zero_q   <= 1'b0;
      res_valid    <= 1'b0;
      res_we       <= 1'b0;
      res_addr     <= '0;
      res_data     <= '0;
      res_br_taken <= 1'b0;
      res_exc_ovf  <= 1'b0;
      res_illegal  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && in_valid) begin
        instr_q <= in_instr;
        rs_q    <= in_rs_val;
        rt_q    <= in_rt_val;
      end
      if (state_q == S_DECODE) begin
        alu_opr1  <= opr1_d;
        alu_opr2  <= opr2_d;
        alu_ctrl  <= dec.ctrl;
        cls_q     <= dec.cls;
        dest_q    <= dec.dest;
        ovf_chk_q <= dec.ovf_chk;
        br_ne_q   <= dec.br_ne;
        cnt_q     <= '0;
      end
      if (state_q == S_EXEC) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(EXEC_CYCLES - 1)) begin
          cap_res_q  <= alu_result;
          cap_ovf_q  <= alu_overflow;
          cap_zero_q <= alu_zero;
        end
        if (cnt_q == CW'(EXEC_CYCLES)) begin
          res_valid    <= 1'b1;
          res_we       <= (cls_q == CLS_ALU) && (dest_q != 5'd0) && !trap;
          res_addr     <= dest_q;
          res_data     <= cap_res_q;
          res_br_taken <= (cls_q == CLS_BRANCH) && (cap_zero_q ^ br_ne_q);
          res_exc_ovf  <= trap;
          res_illegal  <= (cls_q == CLS_ILLEGAL);
        end
      end
      if (state_q == S_RESP && res_ready) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural ALU, instruction-level reference model,
// directed table, hand-written handshake/reset sequences and random instructions.
module tb_alu_issue_seq;

`ifdef ALU_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        br;
    logic        ovf;
    logic        ill;
  } res_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    res_t        exp;
  } vec_t;

  localparam logic [5:0] FNS [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                      6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  localparam logic [5:0] OPS [10] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                      6'h0E, 6'h0F};

  logic        clk = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, res_ready = 1'b1;
  logic [31:0] in_instr = '0, in_rs_val = '0, in_rt_val = '0;
  logic [31:0] alu_opr1, alu_opr2, alu_result, res_data;
  logic [3:0]  alu_ctrl;
  logic        alu_overflow, alu_zero, res_valid, res_we, res_br_taken, res_exc_ovf, res_illegal;
  logic [4:0]  res_addr;

  int n_vec = 0, n_err = 0;

  alu_issue_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .alu_opr1(alu_opr1), .alu_opr2(alu_opr2),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .res_valid(res_valid), .res_ready(res_ready), .res_we(res_we),
    .res_addr(res_addr), .res_data(res_data), .res_br_taken(res_br_taken),
    .res_exc_ovf(res_exc_ovf), .res_illegal(res_illegal)
  );

  always #5 clk = ~clk;

  // Behavioural ALU driven by the sequencer's registered controls.
  always_comb begin
    alu_result   = 32'h0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      4'b0000, 4'b0001: alu_result = alu_opr1 + alu_opr2;
      4'b0010, 4'b0011: alu_result = alu_opr1 - alu_opr2;
      4'b0100: alu_result = alu_opr1 & alu_opr2;
      4'b0101: alu_result = alu_opr1 | alu_opr2;
      4'b0110: alu_result = alu_opr1 ^ alu_opr2;
      4'b0111: alu_result = ~(alu_opr1 | alu_opr2);
      4'b1010: alu_result = {31'h0, $signed(alu_opr1) < $signed(alu_opr2)};
      4'b1011: alu_result = {31'h0, alu_opr1 < alu_opr2};
      4'b1100: alu_result = 32'($signed(alu_opr1) >>> alu_opr2[4:0]);
      4'b1101: alu_result = alu_opr1 >> alu_opr2[4:0];
      4'b1110: alu_result = alu_opr2 << 16;
      4'b1111: alu_result = alu_opr1 << alu_opr2[4:0];
      default: ;
    endcase
    if (alu_ctrl == 4'b0000)
      alu_overflow = (alu_opr1[31] == alu_opr2[31]) && (alu_result[31] != alu_opr1[31]);
    else if (alu_ctrl == 4'b0010)
      alu_overflow = (alu_opr1[31] != alu_opr2[31]) && (alu_result[31] != alu_opr1[31]);
    alu_zero = (alu_result == 32'h0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic res_t mk(input logic we, input logic [4:0] addr, input logic [31:0] data,
                              input logic br, input logic ovf, input logic ill);
    res_t r;
    r.we = we; r.addr = addr; r.data = data; r.br = br; r.ovf = ovf; r.ill = ill;
    return r;
  endfunction

  // Instruction semantics computed directly from the MIPS definition.
  function automatic res_t ref_model(input logic [31:0] ins, input logic [31:0] a,
                                     input logic [31:0] b);
    res_t r;
    logic wr, ovf;
    logic [4:0] sh;
    logic [31:0] se, ze;
    logic signed [32:0] w;
    r = '0; wr = 1'b1; ovf = 1'b0; w = '0;
    sh = ins[10:6];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    r.addr = (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: begin r.data = a + b; w = $signed({a[31], a}) + $signed({b[31], b}); ovf = w[32] != w[31]; end
        6'h21: r.data = a + b;
        6'h22: begin r.data = a - b; w = $signed({a[31], a}) - $signed({b[31], b}); ovf = w[32] != w[31]; end
        6'h23: r.data = a - b;
        6'h24: r.data = a & b;
        6'h25: r.data = a | b;
        6'h26: r.data = a ^ b;
        6'h27: r.data = ~(a | b);
        6'h2A: r.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2B: r.data = (a < b) ? 32'd1 : 32'd0;
        6'h00: r.data = b << sh;
        6'h02: r.data = b >> sh;
        6'h03: r.data = 32'($signed(b) >>> sh);
        6'h04: r.data = b << a[4:0];
        6'h06: r.data = b >> a[4:0];
        6'h07: r.data = 32'($signed(b) >>> a[4:0]);
        default: r.ill = 1'b1;
      endcase
      6'h04: begin r.data = a - b; r.br = (a == b); wr = 1'b0; end
      6'h05: begin r.data = a - b; r.br = (a != b); wr = 1'b0; end
      6'h08: begin r.data = a + se; w = $signed({a[31], a}) + $signed({se[31], se}); ovf = w[32] != w[31]; end
      6'h09: r.data = a + se;
      6'h0A: r.data = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
      6'h0B: r.data = (a < se) ? 32'd1 : 32'd0;
      6'h0C: r.data = a & ze;
      6'h0D: r.data = a | ze;
      6'h0E: r.data = a ^ ze;
      6'h0F: r.data = {ins[15:0], 16'h0};
      default: r.ill = 1'b1;
    endcase
    if (r.ill) begin r.data = 32'h0; wr = 1'b0; end
    if (TRAP && ovf) begin r.ovf = 1'b1; wr = 1'b0; end
    r.we = wr && (r.addr != 5'd0);
    return r;
  endfunction

  task automatic chk_res(input string tag, input res_t g, input res_t e);
    chk({tag, ".we"},   32'(g.we),  32'(e.we));
    chk({tag, ".data"}, g.data,     e.data);
    chk({tag, ".br"},   32'(g.br),  32'(e.br));
    chk({tag, ".ovf"},  32'(g.ovf), 32'(e.ovf));
    chk({tag, ".ill"},  32'(g.ill), 32'(e.ill));
    if (e.we) chk({tag, ".addr"}, 32'(g.addr), 32'(e.addr));
  endtask

  function automatic res_t snap();
    return mk(res_we, res_addr, res_data, res_br_taken, res_exc_ovf, res_illegal);
  endfunction

  // Issue one instruction; lat = clock edges from the accepting edge to res_valid.
  task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input int stall, output res_t got, output int lat);
    int n;
    in_instr = ins; in_rs_val = a; in_rt_val = b; in_valid = 1'b1; res_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, ".valid"}, 32'(res_valid), 32'd1);
    got = snap();
    for (int i = 0; i < stall; i++) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t vt[$];
  res_t got, held, e;
  int   lat, n;
  bit   seen;

  initial begin
    vt.push_back('{"add_ovf",   32'h00221820, 32'h7FFFFFFF, 32'h00000001, mk(!TRAP, 5'd3, 32'h80000000, 1'b0, TRAP, 1'b0)});
    vt.push_back('{"sub_ovf",   32'h00221822, 32'h80000000, 32'h00000001, mk(!TRAP, 5'd3, 32'h7FFFFFFF, 1'b0, TRAP, 1'b0)});
    vt.push_back('{"addu_wrap", 32'h00221821, 32'h7FFFFFFF, 32'h00000001, mk(1'b1, 5'd3, 32'h80000000, 1'b0, 1'b0, 1'b0)});
    vt.push_back('{"sra",       32'h00052103, 32'h00000000, 32'h80000000, mk(1'b1, 5'd4, 32'hF8000000, 1'b0, 1'b0, 1'b0)});
    vt.push_back('{"srlv",      32'h01073006, 32'h00000024, 32'h000000F0, mk(1'b1, 5'd6, 32'h0000000F, 1'b0, 1'b0, 1'b0)});
    vt.push_back('{"lui",       32'h3C091234, 32'hDEADBEEF, 32'h00000000, mk(1'b1, 5'd9, 32'h12340000, 1'b0, 1'b0, 1'b0)});
    vt.push_back('{"addiu",     32'h256AFFFF, 32'h00000001, 32'h00000000, mk(1'b1, 5'd10, 32'h00000000, 1'b0, 1'b0, 1'b0)});
    vt.push_back('{"slti",      32'h29AC0001, 32'hFFFFFFFE, 32'h00000000, mk(1'b1, 5'd12, 32'h00000001, 1'b0, 1'b0, 1'b0)});
    vt.push_back('{"ori",       32'h34258000, 32'h00010001, 32'h00000000, mk(1'b1, 5'd5, 32'h00018001, 1'b0, 1'b0, 1'b0)});
    vt.push_back('{"beq",       32'h10220010, 32'h00000005, 32'h00000005, mk(1'b0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0)});
    vt.push_back('{"bne",       32'h14220010, 32'h00000005, 32'h00000005, mk(1'b0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b0)});
    vt.push_back('{"nop_dest0", 32'h00000000, 32'h00000000, 32'h12345678, mk(1'b0, 5'd0, 32'h12345678, 1'b0, 1'b0, 1'b0)});
    vt.push_back('{"ill_op3f",  32'hFC000000, 32'h11111111, 32'h22222222, mk(1'b0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1)});
    vt.push_back('{"ill_fn01",  32'h00221801, 32'h11111111, 32'h22222222, mk(1'b0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1)});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.res_valid", 32'(res_valid), 32'd0);
    chk("rst.alu_ctrl", 32'(alu_ctrl), 32'd1);
    chk("rst.opr1", alu_opr1, 32'h0);
    chk("rst.opr2", alu_opr2, 32'h0);
    chk("rst.res", 32'(snap()), 32'h0);
    reset = 1'b0;
    #1;
    chk("idle.in_ready", 32'(in_ready), 32'd1);

    foreach (vt[i]) begin
      run_op(vt[i].name, vt[i].instr, vt[i].rs, vt[i].rt, 0, got, lat);
      chk({vt[i].name, ".lat"}, 32'(lat), 32'd3);
      chk_res(vt[i].name, got, vt[i].exp);
    end

    // Backpressure: record held 3 cycles, next instruction waits for the handshake.
    in_instr = 32'h256AFFFF; in_rs_val = 32'h00000010; in_rt_val = 32'h0;
    in_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1;
    in_instr = 32'h3C09ABCD;
    n = 0;
    while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp.valid", 32'(res_valid), 32'd1);
    held = snap();
    chk_res("bp.first", held, ref_model(32'h256AFFFF, 32'h00000010, 32'h0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp.hold_valid", 32'(res_valid), 32'd1);
      chk("bp.hold_res", 32'(snap()), 32'(held));
      chk("bp.in_ready", 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.hs_valid", 32'(res_valid), 32'd0);
    chk("bp.hs_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp.accepted", 32'(in_ready), 32'd0);
    lat = 0;
    while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp.lat", 32'(lat), 32'd3);
    chk_res("bp.second", snap(), ref_model(32'h3C09ABCD, 32'h00000010, 32'h0));
    @(posedge clk); #1;

    // Reset during EXEC: outputs clear at once and the result never appears.
    in_instr = 32'h00221821; in_rs_val = 32'h5; in_rt_val = 32'h6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rx.ctrl_before", 32'(alu_ctrl), 32'd1);
    chk("rx.opr1_before", alu_opr1, 32'h5);
    reset = 1'b1;
    #1;
    chk("rx.alu_ctrl", 32'(alu_ctrl), 32'd1);
    chk("rx.opr1", alu_opr1, 32'h0);
    chk("rx.opr2", alu_opr2, 32'h0);
    chk("rx.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; seen |= res_valid; end
    chk("rx.no_replay", 32'(seen), 32'd0);
    chk("rx.in_ready", 32'(in_ready), 32'd1);

    // Random instructions and operands with random backpressure.
    for (int k = 0; k < 200; k++) begin
      logic [31:0] ins, a, b;
      int sel;
      ins = $urandom;
      sel = $urandom_range(0, 29);
      if (sel < 16) begin ins[31:26] = 6'h00; ins[5:0] = FNS[sel]; end
      else if (sel < 26) ins[31:26] = OPS[sel - 16];
      case ($urandom_range(0, 5))
        0: a = 32'h7FFFFFFF; 1: a = 32'h80000000; 2: a = 32'hFFFFFFFF; default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h00000001; 1: b = 32'h80000000; 2: b = a; default: b = $urandom;
      endcase
      e = ref_model(ins, a, b);
      run_op($sformatf("rnd%0d_%h", k, ins), ins, a, b, $urandom_range(0, 2), got, lat);
      chk($sformatf("rnd%0d.lat", k), 32'(lat), 32'd3);
      chk_res($sformatf("rnd%0d_%h", k, ins), got, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
